// File: rtl/rz_frame_scanner.sv
// Readout sequencer: walks six 16-bit receive RAMs (line 1..6, address 0..WORDS-1) onto one valid/ready stream.
// Optional feature: define RZ_SCAN_HEADER_EN to emit a 16'hA50n header word ahead of each line's data.
module rz_frame_scanner #(
   parameter int WORDS = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic [4:0]  rd_arinc1,
   output logic [4:0]  rd_arinc2,
   output logic [4:0]  rd_arinc3,
   output logic [4:0]  rd_arinc4,
   output logic [4:0]  rd_arinc5,
   output logic [4:0]  rd_arinc6,
   input  logic [15:0] arinc_1_outp,
   input  logic [15:0] arinc_2_outp,
   input  logic [15:0] arinc_3_outp,
   input  logic [15:0] arinc_4_outp,
   input  logic [15:0] arinc_5_outp,
   input  logic [15:0] arinc_6_outp,
   output logic [15:0] out_data,
   output logic [2:0]  out_ch,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
`ifdef RZ_SCAN_HEADER_EN
      S_HDR  = 3'd1,
`endif
      S_ADDR = 3'd2,
      S_CAPT = 3'd3,
      S_PRES = 3'd4
   } state_t;

`ifdef RZ_SCAN_HEADER_EN
   localparam state_t LINE_FIRST = S_HDR;
`else
   localparam state_t LINE_FIRST = S_ADDR;
`endif
   localparam logic [4:0] LAST_ADDR = 5'(WORDS - 1);
   localparam logic [2:0] LAST_CH   = 3'd5;

   state_t      state_q, state_d;
   logic [2:0]  ch_q, ch_d;
   logic [4:0]  addr_q, addr_d;
   logic [15:0] data_q, data_d;
   logic        done_q, done_d;
   logic        overrun_q, overrun_d;
   logic [15:0] sel_data;
   logic [4:0]  rd_addr [6];

   // Only the line being read sees the address; the other five RAMs are parked at 0.
   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_rd
         assign rd_addr[gi] = (ch_q == 3'(gi)) ? addr_q : 5'd0;
      end
   endgenerate

   assign rd_arinc1 = rd_addr[0];
   assign rd_arinc2 = rd_addr[1];
   assign rd_arinc3 = rd_addr[2];
   assign rd_arinc4 = rd_addr[3];
   assign rd_arinc5 = rd_addr[4];
   assign rd_arinc6 = rd_addr[5];

   always_comb begin
      sel_data = 16'd0;
      case (ch_q)
         3'd0:    sel_data = arinc_1_outp;
         3'd1:    sel_data = arinc_2_outp;
         3'd2:    sel_data = arinc_3_outp;
         3'd3:    sel_data = arinc_4_outp;
         3'd4:    sel_data = arinc_5_outp;
         3'd5:    sel_data = arinc_6_outp;
         default: sel_data = 16'd0;
      endcase
   end

   assign out_ch  = ch_q + 3'd1;
   assign done    = done_q;
   assign overrun = overrun_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ch_q      <= 3'd0;
         addr_q    <= 5'd0;
         data_q    <= 16'd0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      addr_d    = addr_q;
      data_d    = data_q;
      done_d    = 1'b0;
      // A start that lands in any non-idle cycle, including the final transfer, is dropped.
      overrun_d = overrun_q | (start & (state_q != S_IDLE));
      out_valid = 1'b0;
      out_data  = data_q;
      out_last  = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               ch_d    = 3'd0;
               addr_d  = 5'd0;
               state_d = LINE_FIRST;
            end
         end
`ifdef RZ_SCAN_HEADER_EN
         S_HDR: begin
            out_valid = 1'b1;
            out_data  = {8'hA5, 5'b00000, out_ch};
            if (out_ready) state_d = S_ADDR;
         end
`endif
         S_ADDR: state_d = S_CAPT;
         S_CAPT: begin
            data_d  = sel_data;
            state_d = S_PRES;
         end
         S_PRES: begin
            out_valid = 1'b1;
            out_last  = (ch_q == LAST_CH) && (addr_q == LAST_ADDR);
            if (out_ready) begin
               if (addr_q != LAST_ADDR) begin
                  addr_d  = addr_q + 5'd1;
                  state_d = S_ADDR;
               end else if (ch_q != LAST_CH) begin
                  ch_d    = ch_q + 3'd1;
                  addr_d  = 5'd0;
                  state_d = LINE_FIRST;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rz_frame_scanner.sv
// Bench for rz_frame_scanner: a WORDS=32 and a WORDS=1 instance fed by behavioural RAMs, streams checked against a list model.
module tb_rz_frame_scanner;

`ifdef RZ_SCAN_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, start_a, start_b, ready;
   int unsigned salt;
   int total = 0;
   int bad = 0;

   logic [4:0]  a_rd [6];
   logic [4:0]  b_rd [6];
   logic [15:0] a_mem [6];
   logic [15:0] b_mem [6];
   logic [15:0] a_data, b_data;
   logic [2:0]  a_ch, b_ch;
   logic a_valid, a_last, a_busy, a_done, a_overrun;
   logic b_valid, b_last, b_busy, b_done, b_overrun;

   always #5 clk = ~clk;

   rz_frame_scanner #(.WORDS(32)) dut_a (
      .clock(clk), .reset(reset), .start(start_a),
      .rd_arinc1(a_rd[0]), .rd_arinc2(a_rd[1]), .rd_arinc3(a_rd[2]),
      .rd_arinc4(a_rd[3]), .rd_arinc5(a_rd[4]), .rd_arinc6(a_rd[5]),
      .arinc_1_outp(a_mem[0]), .arinc_2_outp(a_mem[1]), .arinc_3_outp(a_mem[2]),
      .arinc_4_outp(a_mem[3]), .arinc_5_outp(a_mem[4]), .arinc_6_outp(a_mem[5]),
      .out_data(a_data), .out_ch(a_ch), .out_valid(a_valid), .out_ready(ready),
      .out_last(a_last), .busy(a_busy), .done(a_done), .overrun(a_overrun)
   );

   rz_frame_scanner #(.WORDS(1)) dut_b (
      .clock(clk), .reset(reset), .start(start_b),
      .rd_arinc1(b_rd[0]), .rd_arinc2(b_rd[1]), .rd_arinc3(b_rd[2]),
      .rd_arinc4(b_rd[3]), .rd_arinc5(b_rd[4]), .rd_arinc6(b_rd[5]),
      .arinc_1_outp(b_mem[0]), .arinc_2_outp(b_mem[1]), .arinc_3_outp(b_mem[2]),
      .arinc_4_outp(b_mem[3]), .arinc_5_outp(b_mem[4]), .arinc_6_outp(b_mem[5]),
      .out_data(b_data), .out_ch(b_ch), .out_valid(b_valid), .out_ready(ready),
      .out_last(b_last), .busy(b_busy), .done(b_done), .overrun(b_overrun)
   );

   function automatic logic [15:0] ram_word(input int line, input int a);
      return 16'(line * 4096 + a * 97 + int'(salt));
   endfunction

   // Behavioural RAMs: contents are a function of (line, address), one-cycle registered read.
   always @(posedge clk) begin
      for (int n = 0; n < 6; n++) begin
         a_mem[n] <= ram_word(n + 1, int'(a_rd[n]));
         b_mem[n] <= ram_word(n + 1, int'(b_rd[n]));
      end
   end

   bit sel;
   logic [15:0] m_data;
   logic [2:0]  m_ch;
   logic m_valid, m_last, m_busy, m_done;
   assign m_data  = sel ? b_data  : a_data;
   assign m_ch    = sel ? b_ch    : a_ch;
   assign m_valid = sel ? b_valid : a_valid;
   assign m_last  = sel ? b_last  : a_last;
   assign m_busy  = sel ? b_busy  : a_busy;
   assign m_done  = sel ? b_done  : a_done;

   logic [15:0] got_data[$], exp_data[$];
   logic [2:0]  got_ch[$],   exp_ch[$];
   logic        got_last[$], exp_last[$];
   int done_cycle, stall_bad, busy_bad, rd_bad, done_len_bad, exp_done;
   bit timed_out;

   task automatic build_expected(input int words);
      int nwords;
      exp_data.delete(); exp_ch.delete(); exp_last.delete();
      nwords = 0;
      for (int line = 1; line <= 6; line++) begin
         if (HDR) begin
            exp_data.push_back(16'hA500 + 16'(line));
            exp_ch.push_back(3'(line));
            exp_last.push_back(1'b0);
         end
         for (int a = 0; a < words; a++) begin
            exp_data.push_back(ram_word(line, a));
            exp_ch.push_back(3'(line));
            exp_last.push_back(line == 6 && a == words - 1);
            nwords++;
         end
      end
      exp_done = nwords * 3 + (HDR ? 6 : 0) + 1;
   endtask

   function automatic int stream_errs();
      int e = 0;
      for (int i = 0; i < got_data.size() && i < exp_data.size(); i++)
         if (got_data[i] !== exp_data[i] || got_ch[i] !== exp_ch[i] || got_last[i] !== exp_last[i]) e++;
      return e;
   endfunction

   task automatic do_scan(input bit which, input bit rnd, input int restart_at,
                          input int stop_after, input int budget);
      int cyc;
      bit have_hold, fired;
      logic [15:0] h_data;
      logic [2:0]  h_ch;
      logic        h_last;
      sel = which;
      got_data.delete(); got_ch.delete(); got_last.delete();
      done_cycle = -1; stall_bad = 0; busy_bad = 0; rd_bad = 0; done_len_bad = 0; timed_out = 0;
      have_hold = 0; fired = 0; h_data = '0; h_ch = '0; h_last = 0;
      @(posedge clk); #1;
      if (which) start_b = 1'b1; else start_a = 1'b1;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (which && (b_rd[0] | b_rd[1] | b_rd[2] | b_rd[3] | b_rd[4] | b_rd[5]) != 5'd0) rd_bad++;
         if (m_done) begin
            done_cycle = cyc;
            break;
         end
         if (m_busy !== 1'b1) busy_bad++;
         if (have_hold && (m_valid !== 1'b1 || m_data !== h_data || m_ch !== h_ch || m_last !== h_last))
            stall_bad++;
         have_hold = 0;
         if (m_valid) begin
            if (ready) begin
               got_data.push_back(m_data); got_ch.push_back(m_ch); got_last.push_back(m_last);
            end else begin
               have_hold = 1; h_data = m_data; h_ch = m_ch; h_last = m_last;
            end
         end
         if (stop_after > 0 && got_data.size() == stop_after) return;
         if (cyc >= budget) begin
            timed_out = 1;
            return;
         end
         @(posedge clk); #1;
         ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (!fired && restart_at > 0 && got_data.size() >= restart_at) begin
            start_a = 1'b1; fired = 1;
         end else start_a = 1'b0;
      end
      @(negedge clk);
      if (m_done !== 1'b0) done_len_bad++;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) begin bad++;
         $display("FAIL reset_ctrl: valid=%b busy=%b done=%b want 000", a_valid, a_busy, a_done); end
      total++; if (a_overrun !== 1'b0 || a_last !== 1'b0) begin bad++;
         $display("FAIL reset_flags: overrun=%b last=%b want 00", a_overrun, a_last); end
      total++; if (a_data !== 16'd0) begin bad++;
         $display("FAIL reset_data: got=%h want=0000", a_data); end
      total++; if ((a_rd[0] | a_rd[1] | a_rd[2] | a_rd[3] | a_rd[4] | a_rd[5]) !== 5'd0) begin bad++;
         $display("FAIL reset_rd: some rd_arinc nonzero"); end
   endtask

   task automatic test_scan_ready_high;
      build_expected(32);
      do_scan(0, 0, -1, 0, 2000);
      total++; if (timed_out || got_data.size() != exp_data.size()) begin bad++;
         $display("FAIL scan_count: got=%0d want=%0d timeout=%0d", got_data.size(), exp_data.size(), timed_out); end
      total++; if (stream_errs() !== 0) begin bad++;
         $display("FAIL scan_words: mismatching=%0d want=0", stream_errs()); end
      total++; if (done_cycle !== exp_done) begin bad++;
         $display("FAIL scan_done_cycle: got=%0d want=%0d", done_cycle, exp_done); end
      total++; if (busy_bad !== 0 || done_len_bad !== 0) begin bad++;
         $display("FAIL scan_busy_done: busy_gaps=%0d long_done=%0d want 0 0", busy_bad, done_len_bad); end
      total++; if (a_busy !== 1'b0 || a_overrun !== 1'b0) begin bad++;
         $display("FAIL scan_after: busy=%b overrun=%b want 0 0", a_busy, a_overrun); end
      $display("scan ready-high: words=%0d done_cycle=%0d", got_data.size(), done_cycle);
   endtask

   task automatic test_random_ready;
      build_expected(32);
      do_scan(0, 1, -1, 0, 5000);
      total++; if (timed_out || got_data.size() != exp_data.size()) begin bad++;
         $display("FAIL rnd_count: got=%0d want=%0d timeout=%0d", got_data.size(), exp_data.size(), timed_out); end
      total++; if (stream_errs() !== 0) begin bad++;
         $display("FAIL rnd_words: mismatching=%0d want=0", stream_errs()); end
      total++; if (stall_bad !== 0) begin bad++;
         $display("FAIL rnd_stall_hold: unstable=%0d want=0", stall_bad); end
      $display("scan random-ready: words=%0d done_cycle=%0d", got_data.size(), done_cycle);
   endtask

   task automatic test_overrun;
      build_expected(32);
      do_scan(0, 0, 20, 0, 2000);
      total++; if (timed_out || got_data.size() != exp_data.size() || stream_errs() !== 0) begin bad++;
         $display("FAIL ovr_scan: got=%0d words (%0d bad) want=%0d", got_data.size(), stream_errs(), exp_data.size()); end
      total++; if (a_overrun !== 1'b1) begin bad++;
         $display("FAIL ovr_flag: got=%b want=1", a_overrun); end
      repeat (5) @(negedge clk);
      total++; if (a_overrun !== 1'b1 || a_busy !== 1'b0) begin bad++;
         $display("FAIL ovr_sticky: overrun=%b busy=%b want 1 0", a_overrun, a_busy); end
      do_scan(0, 0, -1, 0, 2000);
      total++; if (got_data.size() != exp_data.size() || stream_errs() !== 0 || done_cycle !== exp_done) begin bad++;
         $display("FAIL ovr_rescan: words=%0d bad=%0d done=%0d want %0d 0 %0d",
                  got_data.size(), stream_errs(), done_cycle, exp_data.size(), exp_done); end
      $display("scan overrun: words=%0d overrun=%b", got_data.size(), a_overrun);
   endtask

   task automatic test_reset_mid;
      build_expected(32);
      do_scan(0, 0, -1, 50, 2000);
      total++; if (got_data.size() != 50) begin bad++;
         $display("FAIL mid_reach50: got=%0d want=50", got_data.size()); end
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      total++; if (a_valid !== 1'b0 || a_busy !== 1'b0 || a_overrun !== 1'b0 || a_data !== 16'd0) begin bad++;
         $display("FAIL mid_reset_out: valid=%b busy=%b overrun=%b data=%h want 0 0 0 0000",
                  a_valid, a_busy, a_overrun, a_data); end
      total++; if ((a_rd[0] | a_rd[1] | a_rd[2] | a_rd[3] | a_rd[4] | a_rd[5]) !== 5'd0) begin bad++;
         $display("FAIL mid_reset_rd: some rd_arinc nonzero want all 0"); end
      do_scan(0, 0, -1, 0, 2000);
      total++; if (got_data.size() != exp_data.size() || stream_errs() !== 0 || done_cycle !== exp_done) begin bad++;
         $display("FAIL mid_restart: words=%0d bad=%0d done=%0d want %0d 0 %0d",
                  got_data.size(), stream_errs(), done_cycle, exp_data.size(), exp_done); end
      $display("scan after mid reset: words=%0d first=%h", got_data.size(), got_data.size() > 0 ? got_data[0] : 16'h0);
   endtask

   task automatic test_words1;
      build_expected(1);
      do_scan(1, 0, -1, 0, 500);
      total++; if (timed_out || got_data.size() != exp_data.size()) begin bad++;
         $display("FAIL w1_count: got=%0d want=%0d", got_data.size(), exp_data.size()); end
      total++; if (stream_errs() !== 0) begin bad++;
         $display("FAIL w1_words: mismatching=%0d want=0", stream_errs()); end
      total++; if (done_cycle !== exp_done) begin bad++;
         $display("FAIL w1_done_cycle: got=%0d want=%0d", done_cycle, exp_done); end
      total++; if (rd_bad !== 0) begin bad++;
         $display("FAIL w1_rd_zero: nonzero cycles=%0d want=0", rd_bad); end
      do_scan(1, 1, -1, 0, 500);
      total++; if (got_data.size() != exp_data.size() || stream_errs() !== 0 || stall_bad !== 0) begin bad++;
         $display("FAIL w1_random: words=%0d bad=%0d unstable=%0d want %0d 0 0",
                  got_data.size(), stream_errs(), stall_bad, exp_data.size()); end
      $display("scan words=1: words=%0d done_cycle=%0d", got_data.size(), exp_done);
   endtask

   initial begin
      salt = $urandom;
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ready = 1'b1; sel = 1'b0;
      test_reset;
      test_scan_ready_high;
      test_random_ready;
      test_overrun;
      test_reset_mid;
      test_words1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
